avl_rdata_checker: RTL and testbench



---
 rtl/avl_rdata_checker_if.sv | 21 ++
 rtl/avl_rdata_checker.sv | 215 +++++++++++++++++++++
 tb/tb_avl_rdata_checker.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avl_rdata_checker_if.sv
// Avalon read-data stream seen by avl_rdata_checker: calibration status,
// beat valid and beat data.
interface avl_rdata_checker_if #(
   parameter int unsigned DATA_W = 512
);
   logic              local_init_done;
   logic              avl_readdatavalid;
   logic [DATA_W-1:0] avl_readdata;

   modport master (
      output local_init_done,
      output avl_readdatavalid,
      output avl_readdata
   );

   modport slave (
      input local_init_done,
      input avl_readdatavalid,
      input avl_readdata
   );
endinterface

// File: rtl/avl_rdata_checker.sv
// Checks the DDR3 Avalon read stream against the regenerated LFSR pattern.
// Optional sticky per-lane mismatch output: define AVL_CHK_LANE_MASK_EN.
module avl_rdata_checker #(
   parameter int unsigned DATA_W = 512,
   parameter int unsigned ADDR_W = 24,
   parameter logic [31:0] SEED   = 32'h0000_0001
) (
   input  logic                iCLK,
   input  logic                iRST_n,
   input  logic                iSTART,
   input  logic [ADDR_W-1:0]   iBEATS,
   avl_rdata_checker_if.slave  avl,
   output logic [ADDR_W-1:0]   oBEAT_CNT,
   output logic [15:0]         oERR_CNT,
   output logic [ADDR_W-1:0]   oFIRST_ERR_BEAT,
   output logic                oSTRAY,
   output logic                oDONE,
   output logic                oPASS,
   output logic                oFAIL
`ifdef AVL_CHK_LANE_MASK_EN
   ,
   output logic [DATA_W/32-1:0] oERR_LANES
`endif
);

   localparam int unsigned LANES    = DATA_W / 32;
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_CHECK,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] beats_q, beats_d;
   logic [31:0]       lfsr_q, lfsr_d;
   logic [ADDR_W-1:0] beat_cnt_q, beat_cnt_d;
   logic              s1_vld_q, s1_vld_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [DATA_W-1:0] s1_exp_q, s1_exp_d;
   logic [ADDR_W-1:0] s1_idx_q, s1_idx_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0] first_err_q, first_err_d;
   logic              stray_q, stray_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
`ifdef AVL_CHK_LANE_MASK_EN
   logic [LANES-1:0]  lanes_q, lanes_d;
`endif

   logic [DATA_W-1:0] exp_word;
   logic [LANES-1:0]  mis_mask;
   logic              mis_any;
   logic              accept;
   logic              stray_hit;

   assign accept    = (state_q == ST_CHECK) && avl.avl_readdatavalid && !iSTART;
   assign stray_hit = (state_q != ST_CHECK) && avl.avl_readdatavalid;

   // Lane k of the expected word is the current LFSR value XORed with k.
   always_comb begin
      exp_word = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         exp_word[32*k +: 32] = lfsr_q ^ k;
      end
   end

   always_comb begin
      mis_mask = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         mis_mask[k] = s1_vld_q && (s1_data_q[32*k +: 32] != s1_exp_q[32*k +: 32]);
      end
   end

   assign mis_any = |mis_mask;

   always_comb begin
      state_d     = state_q;
      beats_d     = beats_q;
      lfsr_d      = lfsr_q;
      beat_cnt_d  = beat_cnt_q;
      s1_vld_d    = accept;
      s1_data_d   = s1_data_q;
      s1_exp_d    = s1_exp_q;
      s1_idx_d    = s1_idx_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      stray_d     = stray_q | stray_hit;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
`ifdef AVL_CHK_LANE_MASK_EN
      lanes_d     = lanes_q | mis_mask;
`endif

      unique case (state_q)
         ST_IDLE:  state_d = ST_IDLE;
         ST_ARM: begin
            if (avl.local_init_done) begin
               state_d = (beats_q == '0) ? ST_DONE : ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (accept && ((beat_cnt_q + ADDR_W'(1)) == beats_q)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!s1_vld_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase

      if (accept) begin
         s1_data_d  = avl.avl_readdata;
         s1_exp_d   = exp_word;
         s1_idx_d   = beat_cnt_q;
         beat_cnt_d = beat_cnt_q + ADDR_W'(1);
         lfsr_d     = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
      end

      // Counter commits alongside the stage-2 mask, giving t+2 visibility.
      if (mis_any) begin
         if (err_cnt_q == '0) begin
            first_err_d = s1_idx_q;
         end
         if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
      end

      // Verdict latches on entry to DONE; a stray beat in that same cycle counts.
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
         done_d = 1'b1;
         pass_d = (err_cnt_d == '0) && !stray_d;
         fail_d = !((err_cnt_d == '0) && !stray_d);
      end

      if (iSTART) begin
         state_d     = ST_ARM;
         beats_d     = iBEATS;
         lfsr_d      = SEED_EFF;
         beat_cnt_d  = '0;
         s1_vld_d    = 1'b0;
         err_cnt_d   = '0;
         first_err_d = '0;
         stray_d     = 1'b0;
         done_d      = 1'b0;
         pass_d      = 1'b0;
         fail_d      = 1'b0;
`ifdef AVL_CHK_LANE_MASK_EN
         lanes_d     = '0;
`endif
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_n) begin
         state_q     <= ST_IDLE;
         beats_q     <= '0;
         lfsr_q      <= SEED_EFF;
         beat_cnt_q  <= '0;
         s1_vld_q    <= 1'b0;
         s1_data_q   <= '0;
         s1_exp_q    <= '0;
         s1_idx_q    <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         stray_q     <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
`ifdef AVL_CHK_LANE_MASK_EN
         lanes_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         beats_q     <= beats_d;
         lfsr_q      <= lfsr_d;
         beat_cnt_q  <= beat_cnt_d;
         s1_vld_q    <= s1_vld_d;
         s1_data_q   <= s1_data_d;
         s1_exp_q    <= s1_exp_d;
         s1_idx_q    <= s1_idx_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         stray_q     <= stray_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
`ifdef AVL_CHK_LANE_MASK_EN
         lanes_q     <= lanes_d;
`endif
      end
   end

   assign oBEAT_CNT       = beat_cnt_q;
   assign oERR_CNT        = err_cnt_q;
   assign oFIRST_ERR_BEAT = first_err_q;
   assign oSTRAY          = stray_q;
   assign oDONE           = done_q;
   assign oPASS           = pass_q;
   assign oFAIL           = fail_q;
`ifdef AVL_CHK_LANE_MASK_EN
   assign oERR_LANES      = lanes_q;
`endif

endmodule

// File: tb/tb_avl_rdata_checker.sv
// Directed bench for avl_rdata_checker with an independent LFSR/expected-word model.
module tb_avl_rdata_checker;

   localparam int unsigned DATA_W = 512;
   localparam int unsigned ADDR_W = 24;
   localparam logic [31:0] SEED   = 32'h0000_0001;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] beats;
   logic [ADDR_W-1:0] beat_cnt;
   logic [15:0]       err_cnt;
   logic [ADDR_W-1:0] first_err;
   logic              stray, done, pass, fail;
`ifdef AVL_CHK_LANE_MASK_EN
   logic [15:0]       err_lanes;
`endif

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   logic [31:0] m_lfsr;
   logic [DATA_W-1:0] w;

   avl_rdata_checker_if #(.DATA_W(DATA_W)) avl_bus ();

   avl_rdata_checker #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .SEED   (SEED)
   ) dut (
      .iCLK            (clk),
      .iRST_n          (rst_n),
      .iSTART          (start),
      .iBEATS          (beats),
      .avl             (avl_bus),
      .oBEAT_CNT       (beat_cnt),
      .oERR_CNT        (err_cnt),
      .oFIRST_ERR_BEAT (first_err),
      .oSTRAY          (stray),
      .oDONE           (done),
      .oPASS           (pass),
      .oFAIL           (fail)
`ifdef AVL_CHK_LANE_MASK_EN
      ,
      .oERR_LANES      (err_lanes)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] next_lfsr(input logic [31:0] l);
      return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
   endfunction

   function automatic logic [DATA_W-1:0] exp_word(input logic [31:0] l);
      logic [DATA_W-1:0] r;
      for (int k = 0; k < 16; k++) r[32*k +: 32] = l ^ 32'(k);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_good(output logic [DATA_W-1:0] d);
      d = exp_word(m_lfsr);
      m_lfsr = next_lfsr(m_lfsr);
   endtask

   task automatic beat(input logic [DATA_W-1:0] d);
      avl_bus.avl_readdatavalid = 1'b1;
      avl_bus.avl_readdata      = d;
      tick();
      avl_bus.avl_readdatavalid = 1'b0;
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] n);
      start = 1'b1;
      beats = n;
      tick();
      start = 1'b0;
      m_lfsr = SEED;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".beat_cnt"}, 32'(beat_cnt), 32'd0);
      check({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
      check({tag, ".first_err"}, 32'(first_err), 32'd0);
      check({tag, ".stray"}, 32'(stray), 32'd0);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".pass"}, 32'(pass), 32'd0);
      check({tag, ".fail"}, 32'(fail), 32'd0);
`ifdef AVL_CHK_LANE_MASK_EN
      check({tag, ".lanes"}, 32'(err_lanes), 32'd0);
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      beats = '0;
      avl_bus.local_init_done   = 1'b0;
      avl_bus.avl_readdatavalid = 1'b0;
      avl_bus.avl_readdata      = '0;
      m_lfsr = SEED;
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      avl_bus.local_init_done = 1'b1;

      // 4 correct back-to-back beats
      do_start(24'd4);
      tick();
      for (int i = 0; i < 4; i++) begin
         next_good(w);
         beat(w);
      end
      check("t1.beat_cnt", 32'(beat_cnt), 32'd4);
      check("t1.done_t1", 32'(done), 32'd0);
      tick();
      check("t1.done_t2", 32'(done), 32'd0);
      tick();
      check("t1.done_t3", 32'(done), 32'd1);
      check("t1.pass", 32'(pass), 32'd1);
      check("t1.fail", 32'(fail), 32'd0);
      check("t1.err_cnt", 32'(err_cnt), 32'd0);

      // 8 beats with 2-cycle gaps, beat 5 lane 3 bit 0 flipped
      do_start(24'd8);
      tick();
      for (int i = 0; i < 8; i++) begin
         next_good(w);
         if (i == 5) w[96] = ~w[96];
         beat(w);
         if (i == 5) check("t2.err_lat1", 32'(err_cnt), 32'd0);
         if (i < 7) begin
            tick();
            if (i == 5) begin
               check("t2.err_lat2", 32'(err_cnt), 32'd1);
               check("t2.first_lat2", 32'(first_err), 32'd5);
            end
            tick();
         end
      end
      check("t2.beat_cnt", 32'(beat_cnt), 32'd8);
      tick();
      tick();
      check("t2.done", 32'(done), 32'd1);
      check("t2.err_cnt", 32'(err_cnt), 32'd1);
      check("t2.first_err", 32'(first_err), 32'd5);
      check("t2.fail", 32'(fail), 32'd1);
      check("t2.pass", 32'(pass), 32'd0);
`ifdef AVL_CHK_LANE_MASK_EN
      check("t2.lanes", 32'(err_lanes), 32'h0008);
`endif

      // stray beat in IDLE, cleared by start; then stray in DONE
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      beat('0);
      check("t3.stray_idle", 32'(stray), 32'd1);
      do_start(24'd2);
      check("t3.stray_cleared", 32'(stray), 32'd0);
      tick();
      for (int i = 0; i < 2; i++) begin
         next_good(w);
         beat(w);
      end
      tick();
      tick();
      check("t3.done", 32'(done), 32'd1);
      check("t3.pass", 32'(pass), 32'd1);
      beat('0);
      check("t3.stray_done", 32'(stray), 32'd1);
      check("t3.pass_held", 32'(pass), 32'd1);
      check("t3.fail_held", 32'(fail), 32'd0);

      // start held off by local_init_done for 50 cycles
      avl_bus.local_init_done = 1'b0;
      do_start(24'd4);
      repeat (50) tick();
      check("t4.beat_cnt_wait", 32'(beat_cnt), 32'd0);
      check("t4.done_wait", 32'(done), 32'd0);
      avl_bus.local_init_done = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         next_good(w);
         beat(w);
      end
      check("t4.done_early", 32'(done), 32'd0);
      tick();
      tick();
      check("t4.done", 32'(done), 32'd1);
      check("t4.pass", 32'(pass), 32'd1);

      // restart mid-CHECK after 3 of 10 beats
      do_start(24'd10);
      tick();
      for (int i = 0; i < 3; i++) begin
         next_good(w);
         beat(w);
      end
      check("t5.beat_cnt_mid", 32'(beat_cnt), 32'd3);
      do_start(24'd10);
      check("t5.beat_cnt_clr", 32'(beat_cnt), 32'd0);
      tick();
      for (int i = 0; i < 10; i++) begin
         next_good(w);
         beat(w);
      end
      check("t5.beat_cnt", 32'(beat_cnt), 32'd10);
      tick();
      tick();
      check("t5.done", 32'(done), 32'd1);
      check("t5.pass", 32'(pass), 32'd1);
      check("t5.err_cnt", 32'(err_cnt), 32'd0);

      // iBEATS == 0 completes one cycle after init is seen in ARM
      do_start(24'd0);
      check("t6.done_arm", 32'(done), 32'd0);
      tick();
      check("t6.done", 32'(done), 32'd1);
      check("t6.pass", 32'(pass), 32'd1);

      // reset during CHECK
      do_start(24'd5);
      tick();
      for (int i = 0; i < 2; i++) begin
         next_good(w);
         beat(w);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_all_zero("t7");

      // 70000 mismatching beats saturate the error counter
      do_start(24'd70000);
      tick();
      avl_bus.avl_readdatavalid = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         next_good(w);
         w[0] = ~w[0];
         avl_bus.avl_readdata = w;
         tick();
      end
      avl_bus.avl_readdatavalid = 1'b0;
      check("t8.beat_cnt", 32'(beat_cnt), 32'd70000);
      tick();
      tick();
      check("t8.done", 32'(done), 32'd1);
      check("t8.err_cnt", 32'(err_cnt), 32'hFFFF);
      check("t8.first_err", 32'(first_err), 32'd0);
      check("t8.fail", 32'(fail), 32'd1);
      check("t8.stray", 32'(stray), 32'd0);
`ifdef AVL_CHK_LANE_MASK_EN
      check("t8.lanes", 32'(err_lanes), 32'h0001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
